fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 9 +
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and a combinational
// instruction memory: fetch drives the byte address, memory returns the word.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;

  modport master (output imem_addr, input imem_rd);
  modport slave  (input imem_addr, output imem_rd);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps the program counter, reads the instruction
// memory combinationally at PC and registers the fetched word for decode.
// Handles stall, branch redirect (word-aligned), out-of-range halt and a
// saturating count of instructions delivered to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 64,
  parameter logic [31:0] NOP_INSTR  = 32'hE1A0_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  fetch_stage_if.master imem,
  output logic [31:0]  instr_d,
  output logic [31:0]  pc_d,
  output logic [31:0]  pc_plus8_d,
  output logic         valid_d,
  output logic         fetch_fault,
  output logic [15:0]  fetch_count
);

  // One past the last valid byte address; 33 bits so a full 4 GiB memory
  // size does not overflow the comparison.
  localparam logic [32:0] MEM_BYTES = 33'(IMEM_WORDS) * 33'd4;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] pc_d_r;
  logic [31:0] pc_plus8_r;
  logic        valid_r;
  logic        fault_r;
  logic [15:0] count_r;

  logic [31:0] pc_plus4_s;
  logic [31:0] pc_plus8_s;
  logic [31:0] branch_pc_s;
  logic        in_range_s;

  // The memory is addressed by the current PC with no intervening logic.
  assign imem.imem_addr = pc_r;

  // Next-address arithmetic wraps modulo 2^32; branch targets are forced to
  // a word boundary; the range check looks at the PC being fetched now.
  always_comb begin
    pc_plus4_s  = pc_r + 32'd4;
    pc_plus8_s  = pc_r + 32'd8;
    branch_pc_s = {branch_target[31:2], 2'b00};
    if ({1'b0, pc_r} < MEM_BYTES) begin
      in_range_s = 1'b1;
    end else begin
      in_range_s = 1'b0;
    end
  end

  // RUN/HALT control with PC, decode register and counter updates.
  // Priority: reset, then branch redirect, then state-specific behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= RUN;
      pc_r       <= RESET_PC;
      instr_r    <= NOP_INSTR;
      pc_d_r     <= 32'h0000_0000;
      pc_plus8_r <= 32'h0000_0000;
      valid_r    <= 1'b0;
      fault_r    <= 1'b0;
      count_r    <= 16'h0000;
    end else if (branch_taken) begin
      // Redirect wins over stall and also leaves HALT; pc_d/pc_plus8_d keep
      // describing the last real instruction.
      state_r <= RUN;
      pc_r    <= branch_pc_s;
      instr_r <= NOP_INSTR;
      valid_r <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (!in_range_s) begin
            // PC ran off the end of memory: freeze fetch and flag it.
            state_r <= HALT;
            fault_r <= 1'b1;
            instr_r <= NOP_INSTR;
            valid_r <= 1'b0;
          end else if (stall) begin
            // Hold everything so decode keeps the same instruction.
            state_r <= RUN;
          end else begin
            pc_r       <= pc_plus4_s;
            instr_r    <= imem.imem_rd;
            pc_d_r     <= pc_r;
            pc_plus8_r <= pc_plus8_s;
            valid_r    <= 1'b1;
            if (count_r != COUNT_MAX) begin
              count_r <= count_r + 16'd1;
            end else begin
              count_r <= COUNT_MAX;
            end
          end
        end
        HALT: begin
          valid_r <= 1'b0;
          fault_r <= 1'b1;
        end
        default: begin
          // Unreachable encoding: fail safe into the halted, faulted state.
          state_r <= HALT;
          instr_r <= NOP_INSTR;
          valid_r <= 1'b0;
          fault_r <= 1'b1;
        end
      endcase
    end
  end

  assign instr_d     = instr_r;
  assign pc_d        = pc_d_r;
  assign pc_plus8_d  = pc_plus8_r;
  assign valid_d     = valid_r;
  assign fetch_fault = fault_r;
  assign fetch_count = count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a driver applies directed and random
// stimulus and pushes the expected post-edge outputs from a behavioural model
// into a queue; a monitor pops and compares after every rising edge.
module tb_fetch_stage;

  localparam int          W         = 4;
  localparam logic [31:0] MEM_BYTES = 32'(W * 4);
  localparam logic [31:0] NOP       = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus8_d;
  logic        valid_d;
  logic        fetch_fault;
  logic [15:0] fetch_count;

  logic [31:0] mem [W] = '{32'hE3A0_101E, 32'hE3A0_2004, 32'hE5C2_3008, 32'hE5B2_4008};

  fetch_stage_if imem_bus ();

  // Combinational instruction memory; junk outside the populated range.
  assign imem_bus.imem_rd = (imem_bus.imem_addr < MEM_BYTES) ?
                            mem[imem_bus.imem_addr[3:2]] : 32'hDEAD_BEEF;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(W),
    .NOP_INSTR (NOP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem         (imem_bus.master),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .pc_plus8_d   (pc_plus8_d),
    .valid_d      (valid_d),
    .fetch_fault  (fetch_fault),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc8;
    logic        valid;
    logic        fault;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Behavioural model: architectural state of the fetch unit.
  logic [31:0] m_pc    = 32'h0;
  bit          m_halt  = 1'b0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_pcd   = 32'h0;
  logic [31:0] m_pc8   = 32'h0;
  logic        m_valid = 1'b0;
  logic        m_fault = 1'b0;
  logic [15:0] m_cnt   = 16'h0;

  // Apply one cycle of inputs, advance the model, queue what the DUT must show.
  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t);
    @(negedge clk);
    reset         = r;
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    if (r) begin
      m_pc = 32'h0; m_halt = 1'b0; m_instr = NOP; m_pcd = 32'h0;
      m_pc8 = 32'h0; m_valid = 1'b0; m_fault = 1'b0; m_cnt = 16'h0;
    end else if (b) begin
      m_pc    = (t / 32'd4) * 32'd4;
      m_instr = NOP;
      m_valid = 1'b0;
      m_halt  = 1'b0;
      m_fault = 1'b0;
    end else if (m_halt) begin
      m_valid = 1'b0;
    end else if (m_pc >= MEM_BYTES) begin
      m_halt  = 1'b1;
      m_fault = 1'b1;
      m_instr = NOP;
      m_valid = 1'b0;
    end else if (!s) begin
      m_instr = mem[int'(m_pc / 32'd4)];
      m_pcd   = m_pc;
      m_pc8   = m_pc + 32'd8;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
      if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    q.push_back('{addr: m_pc, instr: m_instr, pcd: m_pcd, pc8: m_pc8,
                  valid: m_valid, fault: m_fault, cnt: m_cnt});
  endtask

  // Wait until just after the next rising edge so registered outputs settle.
  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: after each rising edge compare the DUT against the oldest expectation.
  always @(posedge clk) begin : monitor
    exp_t e;
    exp_t a;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {imem_bus.imem_addr, instr_d, pc_d, pc_plus8_d, valid_d, fetch_fault, fetch_count};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL scoreboard t=%0t got addr=%h instr=%h pc_d=%h pc8=%h v=%b f=%b cnt=%h expected addr=%h instr=%h pc_d=%h pc8=%h v=%b f=%b cnt=%h",
                 $time, a.addr, a.instr, a.pcd, a.pc8, a.valid, a.fault, a.cnt,
                 e.addr, e.instr, e.pcd, e.pc8, e.valid, e.fault, e.cnt);
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;

    // Reset state, then sequential fetch of the four words.
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    after_edge();
    chk("reset_instr", instr_d, NOP);
    chk("reset_valid", {31'h0, valid_d}, 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    after_edge();
    chk("seq_count", {16'h0, fetch_count}, 32'd4);
    chk("seq_instr", instr_d, 32'hE5B2_4008);
    chk("seq_pc8", pc_plus8_d, 32'd20);

    // Stall for three cycles after the second fetch.
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    after_edge();
    chk("stall_instr", instr_d, 32'hE3A0_2004);
    chk("stall_pcd", pc_d, 32'd4);
    chk("stall_addr", imem_bus.imem_addr, 32'd8);
    step(0, 0, 0, 0);
    after_edge();
    chk("resume_instr", instr_d, 32'hE5C2_3008);

    // Branch and stall together with a misaligned target.
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 1, 1, 32'h0000_0006);
    after_edge();
    chk("br_addr", imem_bus.imem_addr, 32'd4);
    chk("br_instr", instr_d, NOP);
    chk("br_valid", {31'h0, valid_d}, 32'd0);
    step(0, 0, 0, 0);
    after_edge();
    chk("br_next_instr", instr_d, 32'hE3A0_2004);
    chk("br_next_pcd", pc_d, 32'd4);

    // Run off the end of memory, hold in HALT, recover by branching to 0.
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    after_edge();
    chk("runoff_pcd", pc_d, 32'd12);
    step(0, 0, 0, 0);
    after_edge();
    chk("runoff_fault", {31'h0, fetch_fault}, 32'd1);
    chk("runoff_addr", imem_bus.imem_addr, 32'd16);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    after_edge();
    chk("halt_addr", imem_bus.imem_addr, 32'd16);
    step(0, 0, 1, 32'h0);
    after_edge();
    chk("recover_fault", {31'h0, fetch_fault}, 32'd0);
    step(0, 0, 0, 0);
    after_edge();
    chk("recover_instr", instr_d, 32'hE3A0_101E);

    // Reset while halted with stall asserted.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    after_edge();
    chk("rst_halt_addr", imem_bus.imem_addr, 32'd0);
    chk("rst_halt_fault", {31'h0, fetch_fault}, 32'd0);
    chk("rst_halt_count", {16'h0, fetch_count}, 32'd0);
    step(1, 1, 1, 32'd8);
    after_edge();
    chk("rst_over_branch", imem_bus.imem_addr, 32'd0);

    // Randomized traffic, including misaligned and out-of-range targets.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 12, 32'($urandom_range(0, 31)));
    end

    // Saturate the fetch counter with a looping branch back to word 0.
    step(1, 0, 0, 0);
    while (m_cnt != 16'hFFFF) step(0, 0, m_pc == MEM_BYTES, 32'h0);
    for (int i = 0; i < 8; i++) step(0, 0, m_pc == MEM_BYTES, 32'h0);
    after_edge();
    chk("sat_count", {16'h0, fetch_count}, 32'h0000_FFFF);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
